// File: rtl/rx_frame_capture.sv
// rx_frame_capture: double-buffered capture of ISO/IEC 14443A receive frames.
// One bank is filled by the receiver while the other holds the last completed
// frame for readback. Define RX_FRAME_CAPTURE_CRC_EN to add CRC_A checking of
// the published frame; without it last_crc_ok is tied to 0.
module rx_frame_capture #(
   parameter int DEPTH       = 16,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         soc,
   input  logic                         eoc,
   input  logic [7:0]                   data,
   input  logic [2:0]                   data_bits,
   input  logic                         data_valid,
   input  logic                         sequence_error,
   input  logic                         parity_error,
   input  logic [$clog2(DEPTH)-1:0]     rd_addr,
   output logic [7:0]                   rd_data,
   output logic [3:0]                   rd_bits,
   output logic [$clog2(DEPTH+1)-1:0]   last_bytes,
   output logic                         last_overflow,
   output logic                         last_parity_err,
   output logic                         last_seq_err,
   output logic                         last_crc_ok,
   output logic                         in_frame,
   output logic                         frame_done,
   output logic [COUNT_WIDTH-1:0]       frame_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(DEPTH + 1);
   localparam logic [BW-1:0] FULL = BW'(DEPTH);

   typedef enum logic {IDLE = 1'b0, CAPTURE = 1'b1} state_t;

   state_t state, state_n;

   logic [7:0] mem_data [0:1][0:DEPTH-1];
   logic [3:0] mem_bits [0:1][0:DEPTH-1];

   logic          wbank, wbank_n;
   logic [BW-1:0] wr_ptr, wr_ptr_n;
   logic          ovf, ovf_n, par, par_n, seq, seq_n;
   logic          publish, wr_en, wr_new, wsel;
   logic [AW-1:0] wr_addr;
   logic [3:0]    wr_bits;
   logic [BW-1:0] pub_bytes;
   logic          pub_ovf, pub_par, pub_seq, pub_crc_ok;
   logic [BW-1:0] last_bytes_n;
   logic          rbank, fwd;

   assign wr_bits  = (data_bits == 3'd0) ? 4'd8 : {1'b0, data_bits};
   assign in_frame = (state == CAPTURE);

   // Next state, working pointer/flags and publish/write decisions.
   // A soc in the same cycle as other events means this cycle's byte and
   // errors belong to the new frame; without soc they close out the old one.
   always_comb begin
      state_n   = state;
      wbank_n   = wbank;
      wr_ptr_n  = wr_ptr;
      ovf_n     = ovf;
      par_n     = par;
      seq_n     = seq;
      publish   = 1'b0;
      wr_en     = 1'b0;
      wr_new    = 1'b0;
      wsel      = wbank;
      wr_addr   = wr_ptr[AW-1:0];
      if (state == CAPTURE && !soc) begin
         if (data_valid) begin
            if (wr_ptr != FULL) begin
               wr_en    = 1'b1;
               wr_ptr_n = wr_ptr + BW'(1);
            end else begin
               ovf_n = 1'b1;
            end
         end
         if (parity_error)   par_n = 1'b1;
         if (sequence_error) seq_n = 1'b1;
      end
      pub_bytes = wr_ptr_n;
      pub_ovf   = ovf_n;
      pub_par   = par_n;
      pub_seq   = seq_n;
      if (state == CAPTURE && eoc) begin
         publish = 1'b1;
         wbank_n = ~wbank;
         state_n = IDLE;
      end
      if (soc) begin
         state_n  = CAPTURE;
         wsel     = wbank_n;
         wr_addr  = '0;
         ovf_n    = 1'b0;
         par_n    = parity_error;
         seq_n    = sequence_error;
         wr_new   = data_valid;
         wr_en    = data_valid;
         wr_ptr_n = data_valid ? BW'(1) : '0;
      end
   end

`ifdef RX_FRAME_CAPTURE_CRC_EN
   logic [15:0] crc, crc_n, crc_cur;
   logic        crc_bad, crc_bad_n, bad_cur;

   function automatic logic [15:0] crc_a_byte(input logic [15:0] c_in, input logic [7:0] b);
      logic [15:0] c;
      c = c_in ^ {8'h00, b};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      return c;
   endfunction

   // Running CRC_A over stored full bytes; a stored partial byte poisons it
   always_comb begin
      crc_cur = crc;
      bad_cur = crc_bad;
      if (wr_en && !wr_new) begin
         if (data_bits == 3'd0) crc_cur = crc_a_byte(crc, data);
         else                   bad_cur = 1'b1;
      end
      crc_n     = crc_cur;
      crc_bad_n = bad_cur;
      if (soc) begin
         crc_n     = 16'h6363;
         crc_bad_n = 1'b0;
         if (wr_new) begin
            if (data_bits == 3'd0) crc_n = crc_a_byte(16'h6363, data);
            else                   crc_bad_n = 1'b1;
         end
      end
      pub_crc_ok = (pub_bytes >= BW'(3)) && (crc_cur == 16'h0000) && !pub_ovf && !bad_cur;
   end

   // CRC working state
   always_ff @(posedge clk) begin
      if (rst) begin
         crc     <= 16'h6363;
         crc_bad <= 1'b0;
      end else begin
         crc     <= crc_n;
         crc_bad <= crc_bad_n;
      end
   end
`else
   assign pub_crc_ok = 1'b0;
`endif

   // Capture state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Working capture control and the published frame descriptor
   always_ff @(posedge clk) begin
      if (rst) begin
         wbank           <= 1'b0;
         wr_ptr          <= '0;
         ovf             <= 1'b0;
         par             <= 1'b0;
         seq             <= 1'b0;
         last_bytes      <= '0;
         last_overflow   <= 1'b0;
         last_parity_err <= 1'b0;
         last_seq_err    <= 1'b0;
         last_crc_ok     <= 1'b0;
         frame_count     <= '0;
         frame_done      <= 1'b0;
      end else begin
         wbank      <= wbank_n;
         wr_ptr     <= wr_ptr_n;
         ovf        <= ovf_n;
         par        <= par_n;
         seq        <= seq_n;
         frame_done <= publish;
         if (publish) begin
            last_bytes      <= pub_bytes;
            last_overflow   <= pub_ovf;
            last_parity_err <= pub_par;
            last_seq_err    <= pub_seq;
            last_crc_ok     <= pub_crc_ok;
            frame_count     <= frame_count + COUNT_WIDTH'(1);
         end
      end
   end

   // Bank write port; contents need no reset since reads are masked by last_bytes
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data[wsel][wr_addr] <= data;
         mem_bits[wsel][wr_addr] <= wr_bits;
      end
   end

   // Reads look at the bank and length that will be published after this edge,
   // forwarding a byte that is written to that bank on the same edge.
   assign last_bytes_n = publish ? pub_bytes : last_bytes;
   assign rbank        = ~wbank_n;
   assign fwd          = wr_en && (wsel == rbank) && (wr_addr == rd_addr);

   // Registered read of the published bank
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= 8'h00;
         rd_bits <= 4'd0;
      end else if (BW'(rd_addr) < last_bytes_n) begin
         rd_data <= fwd ? data    : mem_data[rbank][rd_addr];
         rd_bits <= fwd ? wr_bits : mem_bits[rbank][rd_addr];
      end else begin
         rd_data <= 8'h00;
         rd_bits <= 4'd0;
      end
   end

endmodule

// File: tb/tb_rx_frame_capture.sv
// Testbench for rx_frame_capture: directed frames plus randomized traffic,
// checked every cycle against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_rx_frame_capture;

   localparam int DEPTH = 16;
   localparam int CW    = 2;
   localparam int AW    = 4;
   localparam int BW    = 5;
`ifdef RX_FRAME_CAPTURE_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, soc, eoc, data_valid, sequence_error, parity_error;
   logic [7:0]    data;
   logic [2:0]    data_bits;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic [3:0]    rd_bits;
   logic [BW-1:0] last_bytes;
   logic          last_overflow, last_parity_err, last_seq_err, last_crc_ok;
   logic          in_frame, frame_done;
   logic [CW-1:0] frame_count;

   always #5 clk = ~clk;

   rx_frame_capture #(.DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .soc(soc), .eoc(eoc), .data(data),
      .data_bits(data_bits), .data_valid(data_valid),
      .sequence_error(sequence_error), .parity_error(parity_error),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_bits(rd_bits),
      .last_bytes(last_bytes), .last_overflow(last_overflow),
      .last_parity_err(last_parity_err), .last_seq_err(last_seq_err),
      .last_crc_ok(last_crc_ok), .in_frame(in_frame),
      .frame_done(frame_done), .frame_count(frame_count)
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural frame model ----------------
   bit         m_cap;
   int         cur_n;
   logic [7:0] cur_d [DEPTH];
   int         cur_b [DEPTH];
   bit         c_ovf, c_par, c_seq;
   int         pub_n;
   logic [7:0] pub_d [DEPTH];
   int         pub_b [DEPTH];
   bit         p_ovf, p_par, p_seq, p_crc;
   int         m_count;
   bit         m_done;
   logic [7:0] m_rd;
   int         m_rdb;

   function automatic bit frame_crc_ok();
      logic [15:0] c;
      c = 16'h6363;
      if (pub_n < 3 || p_ovf) return 1'b0;
      for (int i = 0; i < pub_n; i++) begin
         if (pub_b[i] != 8) return 1'b0;
         c = c ^ {8'h00, pub_d[i]};
         for (int j = 0; j < 8; j++)
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      end
      return c == 16'h0000;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_cap = 0; cur_n = 0; c_ovf = 0; c_par = 0; c_seq = 0;
         pub_n = 0; p_ovf = 0; p_par = 0; p_seq = 0; p_crc = 0;
         m_count = 0; m_done = 0; m_rd = 8'h00; m_rdb = 0;
      end else begin
         m_done = 0;
         if (m_cap && !soc) begin
            if (data_valid) begin
               if (cur_n < DEPTH) begin
                  cur_d[cur_n] = data;
                  cur_b[cur_n] = (data_bits == 0) ? 8 : int'(data_bits);
                  cur_n++;
               end else c_ovf = 1;
            end
            if (parity_error)   c_par = 1;
            if (sequence_error) c_seq = 1;
         end
         if (m_cap && eoc) begin
            for (int i = 0; i < cur_n; i++) begin
               pub_d[i] = cur_d[i];
               pub_b[i] = cur_b[i];
            end
            pub_n = cur_n; p_ovf = c_ovf; p_par = c_par; p_seq = c_seq;
            p_crc = CRC_ON && frame_crc_ok();
            m_count = (m_count + 1) % (1 << CW);
            m_done = 1;
            m_cap = 0;
         end
         if (soc) begin
            m_cap = 1; cur_n = 0; c_ovf = 0;
            c_par = parity_error; c_seq = sequence_error;
            if (data_valid) begin
               cur_d[0] = data;
               cur_b[0] = (data_bits == 0) ? 8 : int'(data_bits);
               cur_n = 1;
            end
         end
         if (int'(rd_addr) < pub_n) begin
            m_rd = pub_d[rd_addr]; m_rdb = pub_b[rd_addr];
         end else begin
            m_rd = 8'h00; m_rdb = 0;
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("rd_data",         rd_data,         m_rd);
         check("rd_bits",         rd_bits,         m_rdb);
         check("last_bytes",      last_bytes,      pub_n);
         check("last_overflow",   last_overflow,   p_ovf);
         check("last_parity_err", last_parity_err, p_par);
         check("last_seq_err",    last_seq_err,    p_seq);
         check("last_crc_ok",     last_crc_ok,     p_crc);
         check("in_frame",        in_frame,        m_cap);
         check("frame_done",      frame_done,      m_done);
         check("frame_count",     frame_count,     m_count);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input bit s, input bit e, input bit v, input logic [7:0] d,
                       input logic [2:0] b, input bit pe, input bit se);
      soc = s; eoc = e; data_valid = v; data = d; data_bits = b;
      parity_error = pe; sequence_error = se;
      @(posedge clk);
      #2;
      soc = 0; eoc = 0; data_valid = 0; parity_error = 0; sequence_error = 0;
   endtask

   task automatic idle();
      tick(0, 0, 0, 8'h00, 3'd0, 0, 0);
   endtask

   task automatic byte_in(input logic [7:0] d, input logic [2:0] b);
      tick(0, 0, 1, d, b, 0, 0);
   endtask

   logic [7:0] hlta [4];

   initial begin
      hlta[0] = 8'h50; hlta[1] = 8'h00; hlta[2] = 8'h57; hlta[3] = 8'hCD;
      rst = 1; soc = 0; eoc = 0; data_valid = 0; data = 0; data_bits = 0;
      parity_error = 0; sequence_error = 0; rd_addr = 0;
      idle();
      chk_en = 1;
      idle();
      rst = 0;
      idle();
      check("reset_rd_data",  rd_data, 8'h00);
      check("reset_rd_bits",  rd_bits, 4'd0);
      check("reset_bytes",    last_bytes, 0);
      check("reset_count",    frame_count, 0);
      check("reset_in_frame", in_frame, 0);

      // REQA: one 7-bit byte
      tick(1, 0, 0, 8'h00, 3'd0, 0, 0);
      check("reqa_in_frame", in_frame, 1);
      byte_in(8'h26, 3'd7);
      tick(0, 1, 0, 8'h00, 3'd0, 0, 0);
      check("reqa_done",   frame_done, 1);
      check("reqa_bytes",  last_bytes, 1);
      check("reqa_data",   rd_data, 8'h26);
      check("reqa_bits",   rd_bits, 4'd7);
      check("reqa_count",  frame_count, 1);
      check("reqa_crc",    last_crc_ok, 0);
      idle();
      check("reqa_done_one_cycle", frame_done, 0);

      // HLTA with valid CRC_A
      tick(1, 0, 0, 8'h00, 3'd0, 0, 0);
      for (int i = 0; i < 4; i++) byte_in(hlta[i], 3'd0);
      tick(0, 1, 0, 8'h00, 3'd0, 0, 0);
      check("hlta_bytes", last_bytes, 4);
      check("hlta_crc",   last_crc_ok, CRC_ON);
      for (int i = 0; i < 4; i++) begin
         rd_addr = AW'(i);
         idle();
         check("hlta_rd_data", rd_data, hlta[i]);
         check("hlta_rd_bits", rd_bits, 4'd8);
      end
      rd_addr = 4'd4;
      idle();
      check("hlta_rd_past_end", rd_data, 8'h00);

      // Overflow: 18 full bytes and a parity error
      tick(1, 0, 0, 8'h00, 3'd0, 0, 0);
      for (int i = 0; i < 18; i++) tick(0, 0, 1, 8'h10 + 8'(i), 3'd0, i == 5, 0);
      tick(0, 1, 0, 8'h00, 3'd0, 0, 0);
      check("ovf_bytes", last_bytes, 16);
      check("ovf_flag",  last_overflow, 1);
      check("ovf_par",   last_parity_err, 1);
      check("ovf_seq",   last_seq_err, 0);
      check("ovf_count", frame_count, 3);
      rd_addr = 4'd15;
      idle();
      check("ovf_byte15", rd_data, 8'h1F);

      // Frame A published, frame B in progress, soc+eoc publishes B
      tick(1, 0, 0, 8'h00, 3'd0, 0, 0);
      byte_in(8'hA0, 3'd0); byte_in(8'hA1, 3'd0); byte_in(8'hA2, 3'd0);
      tick(0, 1, 0, 8'h00, 3'd0, 0, 0);
      tick(1, 0, 0, 8'h00, 3'd0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         rd_addr = AW'(i);
         if (i < 5) byte_in(8'hB0 + 8'(i), 3'd0);
         else       idle();
         if (i == 1) check("during_b_reads_a", rd_data, 8'hA1);
      end
      rd_addr = 4'd2;
      tick(1, 1, 0, 8'h00, 3'd0, 0, 0);
      check("soc_eoc_done",     frame_done, 1);
      check("soc_eoc_bytes",    last_bytes, 5);
      check("soc_eoc_data",     rd_data, 8'hB2);
      check("soc_eoc_in_frame", in_frame, 1);
      byte_in(8'hC0, 3'd0); byte_in(8'hC1, 3'd0);
      rst = 1;
      idle();
      rst = 0;
      check("rst_mid_bytes",    last_bytes, 0);
      check("rst_mid_count",    frame_count, 0);
      check("rst_mid_done",     frame_done, 0);
      check("rst_mid_in_frame", in_frame, 0);
      check("rst_mid_rd",       rd_data, 8'h00);

      // Five frames wrap a 2-bit counter to 1; IDLE ignores data and eoc
      rd_addr = 4'd0;
      for (int f = 0; f < 5; f++) begin
         tick(1, 0, 0, 8'h00, 3'd0, 0, 0);
         byte_in(8'(f), 3'd0);
         tick(0, 1, 0, 8'h00, 3'd0, 0, 0);
      end
      check("count_wrap", frame_count, 1);
      tick(0, 1, 1, 8'h77, 3'd0, 1, 1);
      check("idle_ignore_count", frame_count, 1);
      check("idle_ignore_done",  frame_done, 0);
      check("idle_ignore_bytes", last_bytes, 1);
      check("idle_ignore_par",   last_parity_err, 0);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         bit s, e, v, pe, se;
         logic [7:0] d;
         logic [2:0] b;
         rst = ($urandom_range(0, 999) < 3);
         s  = ($urandom_range(0, 99) < 6);
         e  = ($urandom_range(0, 99) < 6);
         v  = ($urandom_range(0, 99) < 50);
         pe = ($urandom_range(0, 99) < 3);
         se = ($urandom_range(0, 99) < 3);
         if (s) begin
            pe = 0; se = 0;
            if (e) v = 0;
         end
         d = 8'($urandom);
         b = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         rd_addr = AW'($urandom);
         tick(s, e, v, d, b, pe, se);
      end
      rst = 0;
      idle();
      idle();
      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
